uart_rx_port: RTL

Bus-attached UART receiver peripheral: the receive counterpart of the existing UART transmit port on the IO bus. It deserialises 8N1 frames from a serial input pin into a small receive FIFO. It answers CPU byte/word reads and status accesses through the same toggle run/done bus handshake used by the memory and IO responders. It sits on the IO bus select alongside the transmit logic.

---
 rtl/uart_rx_port_pkg.sv | 36 +++
 rtl/uart_rx_port_if.sv | 12 +
 rtl/uart_rx_fifo.sv | 48 ++++
 rtl/uart_rx_port.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_port_pkg.sv
// Shared IO-bus definitions for the UART receive port: bus commands, register
// offsets, STATUS bit positions and the receiver state encoding.
package uart_rx_port_pkg;

    localparam logic [1:0] CMD_READ    = 2'b00;
    localparam logic [1:0] CMD_WRITE   = 2'b01;
    localparam logic [1:0] CMD_READ_B  = 2'b10;
    localparam logic [1:0] CMD_WRITE_B = 2'b11;

    localparam logic [15:0] UART_RX_DATA   = 16'h0000;
    localparam logic [15:0] UART_RX_STATUS = 16'h0002;

    localparam int unsigned ST_RDY     = 0;
    localparam int unsigned ST_OVR     = 1;
    localparam int unsigned ST_FERR    = 2;
    localparam int unsigned ST_PERR    = 3;
    localparam int unsigned ST_CNT_LSB = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    function automatic logic is_read_cmd(input logic [1:0] c);
        return (c == CMD_READ) || (c == CMD_READ_B);
    endfunction

    function automatic logic is_write_cmd(input logic [1:0] c);
        return (c == CMD_WRITE) || (c == CMD_WRITE_B);
    endfunction

endpackage

// File: rtl/uart_rx_port_if.sv
// IO-bus toggle run/done handshake as seen by the UART receive port.
interface uart_rx_port_if;
    logic [15:0] addr;
    logic [1:0]  cmd;
    logic        run;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        done;

    modport master (output addr, cmd, run, wr_data, input rd_data, done);
    modport slave  (input addr, cmd, run, wr_data, output rd_data, done);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only if a pop frees a slot.
module uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic [7:0]                        i_din,
    output logic [7:0]                        o_dout,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [NW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == NW'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_rd)      r_count <= r_count + NW'(1);
            else if (!w_wr && w_rd) r_count <= r_count - NW'(1);
        end
    end
endmodule

// File: rtl/uart_rx_port.sv
// UART receive port on the IO bus: 8N1 deserialiser into a FIFO with DATA/STATUS
// registers. Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_port
    import uart_rx_port_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_rx_port_if.slave  bus,
    input  logic           uart_rxp,
    output logic           rx_ready
);
    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned CW  = $clog2(DIV + 1);
    localparam int unsigned NW  = $clog2(FIFO_DEPTH + 1);

    rx_state_t     r_state, w_state_nxt;
    logic          r_sync1, r_sync2;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_ovr, r_ferr, r_perr;
    logic          r_done, r_rx_ready;
    logic [15:0]   r_rd_data;

    logic w_rxs, w_tick, w_sample, w_bit_clr, w_push, w_ferr_set, w_perr_set, w_par_bad;
    logic w_pending, w_is_read, w_sel_data, w_sel_stat, w_pop, w_w1c, w_ovr_set;
    logic w_full, w_empty;
    logic [7:0]    w_dout;
    logic [NW-1:0] w_count;
    logic [15:0]   w_status, w_rd_value;
    logic          w_unused_bits;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxp;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= RX_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RX_IDLE:      if (!w_rxs) w_state_nxt = RX_START;
            RX_START:     if (w_tick) w_state_nxt = w_rxs ? RX_IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
            RX_DATA:      if (w_tick && r_bit_idx == 3'd7) w_state_nxt = RX_PARITY;
            RX_PARITY:    if (w_tick) w_state_nxt = RX_STOP;
`else
            RX_DATA:      if (w_tick && r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
`endif
            RX_STOP:      if (w_tick) w_state_nxt = w_rxs ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (w_rxs) w_state_nxt = RX_IDLE;
            default:      w_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        w_sample   = 1'b0;
        w_bit_clr  = 1'b0;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        w_perr_set = 1'b0;
        unique case (r_state)
            RX_START: w_bit_clr = w_tick & ~w_rxs;
            RX_DATA:  w_sample  = w_tick;
`ifdef UART_RX_PARITY_EN
            RX_PARITY: w_perr_set = w_tick & ((^r_shift) ^ w_rxs);
`endif
            RX_STOP: begin
                w_push     = w_tick & w_rxs & ~w_par_bad;
                w_ferr_set = w_tick & ~w_rxs;
            end
            default: ;
        endcase
    end

    // Counter reloads continuously in IDLE so the half-bit delay is ready on the start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == RX_IDLE) r_cnt <= CW'(DIV / 2);
            else if (w_tick)        r_cnt <= CW'(DIV);
            else                    r_cnt <= r_cnt - CW'(1);
            if (w_bit_clr)     r_bit_idx <= '0;
            else if (w_sample) r_bit_idx <= r_bit_idx + 3'd1;
            if (w_sample) r_shift <= {w_rxs, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_par_bad <= 1'b0;
        else if (w_bit_clr) r_par_bad <= 1'b0;
        else if (w_perr_set) r_par_bad <= 1'b1;
    end
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_pending  = (bus.run != r_done);
    assign w_is_read  = is_read_cmd(bus.cmd);
    assign w_sel_data = (bus.addr[15:1] == UART_RX_DATA[15:1]);
    assign w_sel_stat = (bus.addr[15:1] == UART_RX_STATUS[15:1]);
    assign w_pop      = w_pending & w_is_read & w_sel_data & ~w_empty;
    assign w_w1c      = w_pending & is_write_cmd(bus.cmd) & w_sel_stat;
    assign w_ovr_set  = w_push & w_full & ~w_pop;

    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_shift),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status = '0;
        w_status[ST_RDY]  = r_rx_ready;
        w_status[ST_OVR]  = r_ovr;
        w_status[ST_FERR] = r_ferr;
        w_status[ST_PERR] = r_perr;
        w_status[ST_CNT_LSB +: 4] = 4'(w_count);
    end

    always_comb begin
        w_rd_value = '0;
        if (w_sel_data && !w_empty) w_rd_value = {8'h00, w_dout};
        else if (w_sel_stat)        w_rd_value = w_status;
    end

    // Set terms are OR-ed after the clear so a same-cycle error event survives a W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_data  <= '0;
            r_rx_ready <= 1'b0;
        end else begin
            r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_w1c & bus.wr_data[ST_OVR]));
            r_ferr <= w_ferr_set | (r_ferr & ~(w_w1c & bus.wr_data[ST_FERR]));
            r_perr <= w_perr_set | (r_perr & ~(w_w1c & bus.wr_data[ST_PERR]));
            r_rx_ready <= ~w_empty;
            if (w_pending) begin
                r_done <= ~r_done;
                if (w_is_read) r_rd_data <= w_rd_value;
            end
        end
    end

    assign bus.done      = r_done;
    assign bus.rd_data   = r_rd_data;
    assign rx_ready      = r_rx_ready;
    assign w_unused_bits = ^{bus.wr_data[15:4], bus.wr_data[0], bus.addr[0]};
endmodule
